// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: shares one 4:1 mux output channel among four requesters.
// A rotating-priority search picks the next owner. Each grant lasts until one of
// three things happens: a last beat, MAX_HOLD transfers, or the owner dropping
// req. The mux selects {S1,S0} are registered next to the one-hot grant. They
// keep their last value while idle.
module mux4_rr_arbiter #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req,
  input  logic [3:0]            last,
  input  logic [4*DATA_W-1:0]   data_in,
  output logic [3:0]            ack,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  out_ready,
  output logic [3:0]            gnt,
  output logic                  S0,
  output logic                  S1,
  output logic                  busy
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [CW-1:0]      beat_cnt_q, beat_cnt_d;

  logic [3:0]         req_rot;
  logic [DATA_W-1:0]  data_arr [4];
  logic [1:0]         offset;
  logic [1:0]         winner;
  logic               granted;
  logic               xfer;
  logic [CW-1:0]      cnt_inc;

  // Request vector rotated so bit 0 is the current highest-priority requester.
  // The data bus is also split into per-requester words.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign req_rot[gi]  = req[ptr_q + 2'(gi)];
      assign data_arr[gi] = data_in[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // The lowest set bit of the rotated vector wins. Adding ptr maps it back to a real index.
  always_comb begin
    offset = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req_rot[k]) offset = 2'(k);
    end
    winner = ptr_q + offset;
  end

  // Datapath and handshake. The data is steered by the registered select.
  always_comb begin
    granted   = (state_q == GRANT);
    out_valid = granted & req[sel_q];
    out_data  = granted ? data_arr[sel_q] : '0;
    xfer      = out_valid & out_ready;
    ack       = gnt_q & {4{xfer}};
    cnt_inc   = beat_cnt_q + 1'b1;
  end

  assign gnt  = gnt_q;
  assign S0   = sel_q[0];
  assign S1   = sel_q[1];
  assign busy = granted;

  // Next-state logic: arbitrate in IDLE, count beats and detect release in GRANT.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (|req) begin
          state_d    = GRANT;
          gnt_d      = 4'b0001 << winner;
          sel_d      = winner;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          // Owner abandoned: rotate without acknowledging anything.
          state_d = IDLE;
          gnt_d   = 4'b0000;
          ptr_d   = sel_q + 2'd1;
        end else if (xfer) begin
          beat_cnt_d = cnt_inc;
          if (last[sel_q] || (cnt_inc == HOLD_LIM)) begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            ptr_d   = sel_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State registers with synchronous active-low reset. Reset drops any burst in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 4'b0000;
      sel_q      <= 2'd0;
      ptr_q      <= 2'd0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Testbench for mux4_rr_arbiter. A reference model tracks the current owner,
// the rotation pointer and the beat count as plain integers. Every output is
// compared on every cycle. A directed sequence runs first, then random traffic.
module tb_mux4_rr_arbiter;

  localparam int W    = 8;
  localparam int HOLD = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [3:0]     req;
  logic [3:0]     last;
  logic [4*W-1:0] data_in;
  logic [3:0]     ack;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [3:0]     gnt;
  logic           S0, S1, busy;

  int errors = 0;
  int checks = 0;

  // Reference model state: owner is -1 when idle.
  int         m_owner;
  int         m_ptr;
  int         m_beats;
  logic [1:0] m_sel;

  mux4_rr_arbiter #(.DATA_W(W), .MAX_HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last), .data_in(data_in),
    .ack(ack), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .gnt(gnt), .S0(S0), .S1(S1), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  // One clock cycle: check the outputs against the model, then advance the model
  // with the inputs the DUT samples at the edge.
  task automatic cycle();
    logic [3:0]   eg, ea;
    logic         ev;
    logic [W-1:0] ed;
    #1;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    ev = (m_owner >= 0) && req[m_owner];
    ed = (m_owner >= 0) ? data_in[m_owner*W +: W] : '0;
    ea = (ev && out_ready) ? eg : 4'b0000;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_data", 32'(out_data), 32'(ed));
    chk("ack", 32'(ack), 32'(ea));
    chk("sel", 32'({S1, S0}), 32'(m_sel));
    $display("t=%0t rst_n=%b req=%b last=%b rdy=%b gnt=%b sel=%b ack=%b v=%b d=%h",
             $time, rst_n, req, last, out_ready, gnt, {S1, S0}, ack, out_valid, out_data);
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_beats = 0; m_sel = 2'd0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_sel   = 2'(m_owner);
          m_beats = 0;
        end
      end
    end else if (!req[m_owner]) begin
      m_ptr = (m_owner + 1) % 4; m_owner = -1;
    end else if (out_ready) begin
      m_beats++;
      if (last[m_owner] || m_beats == HOLD) begin
        m_ptr = (m_owner + 1) % 4; m_owner = -1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 4'b0000; last = 4'b0000; out_ready = 1'b1;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; last = '0; data_in = '0; out_ready = 1'b1;
    m_owner = -1; m_ptr = 0; m_beats = 0; m_sel = 2'd0;
    @(posedge clk);
    @(negedge clk);

    // 1: every requester asks with single-beat bursts; the grant rotates every other cycle
    do_reset();
    req = 4'b1111; last = 4'b1111; data_in = 32'h44332211;
    repeat (10) cycle();

    // 2: requester 0 sends a 3-beat burst, then requester 2 gets the channel
    do_reset();
    req = 4'b0101; data_in = 32'h00C000A0;
    repeat (12) begin
      last = (m_owner == 0 && m_beats == 2) ? 4'b0001 : 4'b0000;
      data_in[7:0] = 8'(8'hA0 + m_beats);
      cycle();
    end

    // 3: a sole requester with no last is released after HOLD beats and then re-granted
    do_reset();
    req = 4'b0010; last = 4'b0000; data_in = 32'h00005500;
    repeat (12) cycle();

    // 4: backpressure on requester 3; data is held and ack waits for ready
    do_reset();
    req = 4'b1000; last = 4'b1000; data_in = 32'hA5000000;
    cycle();
    out_ready = 1'b0;
    repeat (3) cycle();
    out_ready = 1'b1;
    repeat (3) cycle();

    // 5: reset during beat 2 of a burst on requester 1, then full requests
    do_reset();
    req = 4'b0010; last = 4'b0000; data_in = 32'h00001100;
    repeat (2) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; req = 4'b1111; last = 4'b1111;
    repeat (4) cycle();

    // 6: requester 2 abandons mid-burst; the pointer moves on to 3
    do_reset();
    req = 4'b0100; last = 4'b0000; data_in = 32'h00770000;
    repeat (2) cycle();
    req = 4'b0000;
    cycle();
    req = 4'b1111;
    repeat (4) cycle();

    // Random traffic with occasional backpressure and resets
    for (int n = 0; n < 600; n++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      req       = 4'($urandom_range(0, 15));
      last      = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      data_in   = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
